// File: rtl/alu_rx_interface_pkg.sv
// Shared ALU definitions: default widths, opcode constants and the
// 3-bit state encoding of the rx/tx sequencer.
package alu_defs;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_CODE_DEF = 6;

  // MIPS funct-field opcodes understood by the ALU
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam logic [2:0] ST_WAIT_A    = 3'd0;
  localparam logic [2:0] ST_WAIT_B    = 3'd1;
  localparam logic [2:0] ST_WAIT_OP   = 3'd2;
  localparam logic [2:0] ST_COMPUTE   = 3'd3;
  localparam logic [2:0] ST_SEND      = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  typedef enum logic [2:0] {
    WAIT_A    = ST_WAIT_A,
    WAIT_B    = ST_WAIT_B,
    WAIT_OP   = ST_WAIT_OP,
    COMPUTE   = ST_COMPUTE,
    SEND      = ST_SEND,
    WAIT_DONE = ST_WAIT_DONE
  } rx_state_e;

endpackage

// File: rtl/alu_rx_interface.sv
// Sequencer between the UART receiver, the ALU and the UART transmitter.
//
// state     | meaning
// ----------+--------------------------------------------------
// WAIT_A    | idle, next byte is operand A
// WAIT_B    | next byte is operand B
// WAIT_OP   | next byte is the opcode (upper bits must be zero)
// COMPUTE   | one cycle for the ALU to settle, result captured
// SEND      | tx_start asserted whenever the transmitter is free
// WAIT_DONE | byte handed off, waiting for tx_done
module alu_rx_interface
  import alu_defs::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_CODE = NB_CODE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               rx_valid,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  output logic [NB_DATA-1:0] dato1,
  output logic [NB_DATA-1:0] dato2,
  output logic [NB_CODE-1:0] op_code,
  input  logic [NB_DATA-1:0] salida,
  output logic               frame_err,
  output logic               overrun
);

  rx_state_e          state_q, state_d;
  logic [NB_DATA-1:0] dato1_q, dato1_d;
  logic [NB_DATA-1:0] dato2_q, dato2_d;
  logic [NB_CODE-1:0] op_code_q, op_code_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  // State and datapath registers, synchronous reset has top priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_A;
      dato1_q     <= '0;
      dato2_q     <= '0;
      op_code_q   <= '0;
      tx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dato1_q     <= dato1_d;
      dato2_q     <= dato2_d;
      op_code_q   <= op_code_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: frame assembly, result capture and tx handshake
  always_comb begin
    state_d     = state_q;
    dato1_d     = dato1_q;
    dato2_d     = dato2_q;
    op_code_d   = op_code_q;
    tx_data_d   = tx_data_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    tx_start    = 1'b0;

    case (state_q)
      WAIT_A: begin
        if (rx_valid) begin
          dato1_d = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_valid) begin
          dato2_d = rx_data;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (rx_valid) begin
          // anything above the funct field means a corrupt frame
          if (rx_data[NB_DATA-1:NB_CODE] == '0) begin
            op_code_d = rx_data[NB_CODE-1:0];
            state_d   = COMPUTE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_A;
          end
        end
      end
      COMPUTE: begin
        tx_data_d = salida;
        state_d   = SEND;
        if (rx_valid) overrun_d = 1'b1;
      end
      SEND: begin
        tx_start = !tx_busy;
        if (!tx_busy) state_d = WAIT_DONE;
        if (rx_valid) overrun_d = 1'b1;
      end
      WAIT_DONE: begin
        if (tx_done) state_d = WAIT_A;
        if (rx_valid) overrun_d = 1'b1;
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign dato1     = dato1_q;
  assign dato2     = dato2_q;
  assign op_code   = op_code_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_rx_interface.sv
// Directed bench for alu_rx_interface with a behavioural ALU on salida.
module tb_alu_rx_interface;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] dato1;
  logic [7:0] dato2;
  logic [5:0] op_code;
  logic [7:0] salida;
  logic       frame_err;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rx_interface #(.NB_DATA(8), .NB_CODE(6)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start),
    .tx_data(tx_data), .dato1(dato1), .dato2(dato2), .op_code(op_code),
    .salida(salida), .frame_err(frame_err), .overrun(overrun)
  );

  // ALU environment model
  always_comb begin
    case (op_code)
      6'b100000: salida = dato1 + dato2;
      6'b100010: salida = dato1 - dato2;
      6'b100100: salida = dato1 & dato2;
      6'b100101: salida = dato1 | dato2;
      6'b100110: salida = dato1 ^ dato2;
      6'b000011: salida = $signed(dato1) >>> dato2;
      6'b000010: salida = dato1 >> dato2;
      6'b100111: salida = ~(dato1 | dato2);
      default:   salida = 8'h00;
    endcase
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // ends in the cycle right after the opcode edge
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({tx_start, tx_data, dato1, dato2, op_code, frame_err, overrun} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {tx_start, tx_data, dato1, dato2, op_code, frame_err, overrun});
    end
  endtask

  // frame then result check; ends in WAIT_DONE without tx_done
  task automatic run_and_check(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] op, input logic [7:0] exp);
    send_frame(a, b, op);
    n_vec++;
    if (dato1 !== a || dato2 !== b || op_code !== op[5:0] || tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL %s_load: got d1=%h d2=%h op=%b st=%b want d1=%h d2=%h op=%b st=0",
               name, dato1, dato2, op_code, tx_start, a, b, op[5:0]);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b1 || tx_data !== exp) begin
      n_err++;
      $display("FAIL %s_result: got st=%b data=%h want st=1 data=%h", name, tx_start, tx_data, exp);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b0 || tx_data !== exp) begin
      n_err++;
      $display("FAIL %s_pulse_end: got st=%b data=%h want st=0 data=%h", name, tx_start, tx_data, exp);
    end
  endtask

  task automatic test_add();
    run_and_check("add", 8'h06, 8'h04, 8'h20, 8'h0A);
    pulse_done();
  endtask

  task automatic test_back_to_back();
    run_and_check("sub", 8'h06, 8'h04, 8'h22, 8'h02);
    pulse_done();
    run_and_check("and", 8'hF0, 8'h3C, 8'h24, 8'h30);
    pulse_done();
  endtask

  task automatic test_backpressure();
    tx_busy = 1'b1;
    send_frame(8'h06, 8'h04, 8'h20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx_start !== 1'b0 || tx_data !== 8'h0A) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got st=%b data=%h want st=0 data=0a", i, tx_start, tx_data);
      end
    end
    tx_busy = 1'b0;
    #1;
    n_vec++;
    if (tx_start !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got st=%b want 1", tx_start);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL bp_pulse_end: got st=%b want 0", tx_start);
    end
    pulse_done();
  endtask

  task automatic test_invalid_opcode();
    send_frame(8'h06, 8'h04, 8'hE0);
    n_vec++;
    if (frame_err !== 1'b1 || tx_start !== 1'b0 || op_code !== 6'b100000) begin
      n_err++;
      $display("FAIL inv_err: got fe=%b st=%b op=%b want fe=1 st=0 op=100000",
               frame_err, tx_start, op_code);
    end
    @(negedge clk);
    n_vec++;
    if (frame_err !== 1'b0 || tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL inv_err_end: got fe=%b st=%b want fe=0 st=0", frame_err, tx_start);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL inv_no_start: got st=%b want 0", tx_start);
    end
    run_and_check("after_inv", 8'h01, 8'h01, 8'h20, 8'h02);
    pulse_done();
  endtask

  task automatic test_overrun();
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_initial: got %b want 0", overrun);
    end
    run_and_check("ovr_frame", 8'h06, 8'h04, 8'h20, 8'h0A);
    send_byte(8'h55);
    n_vec++;
    if (overrun !== 1'b1 || tx_data !== 8'h0A || tx_start !== 1'b0 || dato1 !== 8'h06) begin
      n_err++;
      $display("FAIL ovr_set: got ovr=%b data=%h st=%b d1=%h want ovr=1 data=0a st=0 d1=06",
               overrun, tx_data, tx_start, dato1);
    end
    pulse_done();
    run_and_check("ovr_next", 8'h01, 8'h01, 8'h20, 8'h02);
    pulse_done();
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h06);
    send_byte(8'h04);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({tx_start, tx_data, dato1, dato2, op_code, frame_err, overrun} !== 33'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h want 0",
               {tx_start, tx_data, dato1, dato2, op_code, frame_err, overrun});
    end
    run_and_check("after_reset", 8'h02, 8'h03, 8'h20, 8'h05);
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_invalid_opcode();
    test_overrun();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
